arbitro_rr4: RTL and testbench
==============================

# arbitro_rr4

Round-robin scheduler that shares the single 8-bit output lane of the 4:1 lane mux among four lane FIFOs. Each cycle it picks one eligible requesting lane and pulses that FIFO's read strobe. It drives the mux `selector` and the output `valid_out` aligned with the FIFO read data. It sits between the four lane FIFOs and the 4:1 mux in the clk_4f domain and honours a downstream `pause` backpressure.

## Interface
Parameters:
- `CNT_W`, 16, width of the forwarded-word counter `words_out`.

Ports:
- `clk_4f`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  4  bit i = lane i FIFO non-empty.
- `enable`  in  4  bit i = lane i allowed to be scheduled (static config, may change any cycle).
- `pause`  in  1  downstream almost-full; no new pop issued while high.
- `pop`  out  4  one-hot read strobe to lane FIFOs, registered.
- `selector`  out  2  mux select, registered, aligned with FIFO read data.
- `valid_out`  out  1  output lane word valid, aligned with `selector`.
- `words_out`  out  CNT_W  count of words forwarded (`valid_out` cycles), wraps.

## Operation
- Eligible lane i: `req[i] & enable[i] & ~pop[i]`.
  - The `~pop[i]` term is the cooldown: a lane popped in the current cycle cannot be chosen for the next pop. This guards a 1-deep FIFO against over-read, because `req` lags `pop` by one cycle.
- Round-robin pointer `last` (2 bits):
  - Search order is `last+1`, `last+2`, `last+3`, `last` (mod 4).
  - The first eligible lane wins; `last` updates to the winner only when a pop is issued.
- FSM, 3 states:
  - IDLE: no pop. Go to ISSUE if `~pause` and any lane eligible. Go to PAUSE if `pause`.
  - ISSUE: pop issued this cycle. Stay in ISSUE if `~pause` and any lane eligible. Go to PAUSE if `pause`. Otherwise go to IDLE.
  - PAUSE: no pop. Go to ISSUE when `pause` falls and any lane is eligible; go to IDLE when `pause` falls and no lane is eligible.
  - Decisions use inputs sampled at the edge; `pop` reflects the state entered.
- Data alignment:
  - `selector` = index of the lane popped in the previous cycle.
  - `valid_out` = any `pop` in the previous cycle.
  - `selector` holds its value when `valid_out` = 0.
- `words_out` increments by 1 on each cycle with `valid_out` = 1. It wraps from 2^CNT_W−1 to 0.
- Boundary rules:
  - Single requesting lane: pops on alternate cycles (throughput 1/2).
  - Two or more requesting lanes: back-to-back pops, lanes alternate.
  - `enable[i]` dropped while lane i's pop is in flight: the in-flight word still completes with `valid_out` = 1; lane i receives no further pops.
  - `pause` rising in the same cycle as a pop: that pop completes (`valid_out` next cycle); no pop is issued the following cycle.
  - `req` = 0 or `enable` = 0 everywhere: FSM stays in IDLE and all outputs are quiet.

## Timing
- Reset values:
  - Outputs: `pop` = 0, `selector` = 0, `valid_out` = 0, `words_out` = 0.
  - Internal: state = IDLE, `last` = 3, so lane 0 has first priority.
- Reset mid-operation: all outputs clear asynchronously. Any in-flight pop is dropped, with no `valid_out` for it. After release, the first grant goes to lane 0 if it is eligible.
- Latency:
  - `req` sampled high at edge k → `pop` high in cycle k+1.
  - `valid_out`/`selector` high in cycle k+2, alongside FIFO read data that appears one cycle after `pop`.
- `pause` sampled high at edge k → no `pop` in cycle k+1. `pause` sampled low at edge k → `pop` possible in cycle k+1.
- `pop` is never multi-hot; at most one bit high per cycle.

## Test plan
- Reset, then `req`=4'b1111, `enable`=4'b1111, `pause`=0:
  - `pop` sequence 0001, 0010, 0100, 1000, 0001…, with no bubbles.
  - `selector` 0,1,2,3,0 delayed one cycle from `pop`.
  - `words_out` = 8 after 8 `valid_out` cycles.
- `req`=4'b0100 only: `pop`=0100 every other cycle; `valid_out` toggles 1,0,1; `selector`=2.
- `req`=4'b1111, `enable`=4'b1010: only lanes 1 and 3 are popped, alternating 0010, 1000, back-to-back.
- `req`=4'b0011, `pause` high for 3 cycles starting right after a pop of lane 0:
  - That pop still gives `valid_out`=1, `selector`=0.
  - No pop occurs while paused.
  - The first pop after `pause` falls is lane 1.
- Assert `reset` while `pop`=0010: `pop`, `valid_out`, `selector`, `words_out` go to 0 immediately. After release with `req`=4'b1111, the first pop is 0001.
- Preload `words_out` via 2^CNT_W forwarded words (or CNT_W=4 with 16 words): the counter reads 0 after the 16th word.

Source files
------------

// File: rtl/arbitro_rr4.sv
// rtl/arbitro_rr4.sv - round-robin pop scheduler for four lane FIFOs feeding a 4:1 lane mux
module arbitro_rr4 #(
  parameter int CNT_W = 16
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [3:0]       enable,
  input  logic             pause,
  output logic [3:0]       pop,
  output logic [1:0]       selector,
  output logic             valid_out,
  output logic [CNT_W-1:0] words_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] last;
  logic [3:0] eligible;
  logic       any_eligible;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic [1:0] pop_idx;

  // A lane popped this cycle sits out the next pick: its req still shows the pre-pop level.
  assign eligible     = req & enable & ~pop;
  assign any_eligible = |eligible;

  // Rotating priority search starting just after the last granted lane.
  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && eligible[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Encode the one-hot pop into the lane index the mux needs next cycle.
  always_comb begin
    pop_idx = 2'd0;
    case (pop)
      4'b0010: pop_idx = 2'd1;
      4'b0100: pop_idx = 2'd2;
      4'b1000: pop_idx = 2'd3;
      default: pop_idx = 2'd0;
    endcase
  end

  // Scheduler FSM: decides each cycle whether to issue a pop and to which lane.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      pop   <= 4'b0000;
      last  <= 2'd3;
    end else begin
      case (state)
        ST_IDLE, ST_ISSUE: begin
          if (pause) begin
            state <= ST_PAUSE;
            pop   <= 4'b0000;
          end else if (any_eligible) begin
            state <= ST_ISSUE;
            pop   <= 4'b0001 << winner;
            last  <= winner;
          end else begin
            state <= ST_IDLE;
            pop   <= 4'b0000;
          end
        end
        ST_PAUSE: begin
          if (pause) begin
            state <= ST_PAUSE;
            pop   <= 4'b0000;
          end else if (any_eligible) begin
            state <= ST_ISSUE;
            pop   <= 4'b0001 << winner;
            last  <= winner;
          end else begin
            state <= ST_IDLE;
            pop   <= 4'b0000;
          end
        end
        default: begin
          state <= ST_IDLE;
          pop   <= 4'b0000;
        end
      endcase
    end
  end

  // Output lane alignment: select and valid trail pop by one cycle to meet FIFO read data.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      selector  <= 2'd0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= |pop;
      if (|pop) begin
        selector <= pop_idx;
      end
    end
  end

  // Forwarded-word counter, free-running and wrapping.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      words_out <= '0;
    end else if (valid_out) begin
      words_out <= words_out + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_arbitro_rr4.sv
// tb/tb_arbitro_rr4.sv - directed self-checking bench for arbitro_rr4
module tb_arbitro_rr4;

  localparam int CNT_W = 4;

  logic             clk_4f;
  logic             reset;
  logic [3:0]       req;
  logic [3:0]       enable;
  logic             pause;
  logic [3:0]       pop;
  logic [1:0]       selector;
  logic             valid_out;
  logic [CNT_W-1:0] words_out;

  int               n_cmp;
  int               n_err;
  int               step_no;
  logic [CNT_W-1:0] exp_words;
  logic             prev_valid;

  arbitro_rr4 #(.CNT_W(CNT_W)) dut (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .req      (req),
    .enable   (enable),
    .pause    (pause),
    .pop      (pop),
    .selector (selector),
    .valid_out(valid_out),
    .words_out(words_out)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic check_all(input logic [3:0] ep, input logic ev, input logic [1:0] es);
    n_cmp++;
    assert (pop === ep) else begin
      n_err++;
      $error("FAIL pop step %0d: got %b want %b", step_no, pop, ep);
    end
    n_cmp++;
    assert (valid_out === ev) else begin
      n_err++;
      $error("FAIL valid_out step %0d: got %b want %b", step_no, valid_out, ev);
    end
    n_cmp++;
    assert (selector === es) else begin
      n_err++;
      $error("FAIL selector step %0d: got %0d want %0d", step_no, selector, es);
    end
    n_cmp++;
    assert (words_out === exp_words) else begin
      n_err++;
      $error("FAIL words_out step %0d: got %0d want %0d", step_no, words_out, exp_words);
    end
    n_cmp++;
    assert ($onehot0(pop)) else begin
      n_err++;
      $error("FAIL pop_onehot step %0d: got %b want at most one bit", step_no, pop);
    end
  endtask

  task automatic step(input logic [3:0] ep, input logic ev, input logic [1:0] es);
    @(posedge clk_4f);
    #1;
    step_no++;
    if (prev_valid) exp_words = exp_words + 1'b1;
    check_all(ep, ev, es);
    prev_valid = ev;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    step_no    = 0;
    exp_words  = '0;
    prev_valid = 1'b0;
    reset      = 1'b1;
    req        = 4'b0000;
    enable     = 4'b0000;
    pause      = 1'b0;

    #3;
    check_all(4'b0000, 1'b0, 2'd0);

    req    = 4'b1111;
    enable = 4'b1111;
    #9 reset = 1'b0;

    for (int k = 1; k <= 10; k++) begin
      step(4'b0001 << ((k - 1) % 4), (k >= 2), (k >= 2) ? 2'((k - 2) % 4) : 2'd0);
    end
    n_cmp++;
    assert (words_out === 4'd8) else begin
      n_err++;
      $error("FAIL words_after_8: got %0d want 8", words_out);
    end

    req = 4'b0000;
    step(4'b0000, 1'b1, 2'd1);
    step(4'b0000, 1'b0, 2'd1);

    req = 4'b0100;
    step(4'b0100, 1'b0, 2'd1);
    step(4'b0000, 1'b1, 2'd2);
    step(4'b0100, 1'b0, 2'd2);
    step(4'b0000, 1'b1, 2'd2);
    step(4'b0100, 1'b0, 2'd2);
    step(4'b0000, 1'b1, 2'd2);
    req = 4'b0000;
    step(4'b0000, 1'b0, 2'd2);

    req    = 4'b1111;
    enable = 4'b1010;
    step(4'b1000, 1'b0, 2'd2);
    step(4'b0010, 1'b1, 2'd3);
    step(4'b1000, 1'b1, 2'd1);
    step(4'b0010, 1'b1, 2'd3);
    req = 4'b0000;
    step(4'b0000, 1'b1, 2'd1);
    step(4'b0000, 1'b0, 2'd1);

    enable = 4'b1111;
    req    = 4'b0011;
    step(4'b0001, 1'b0, 2'd1);
    pause = 1'b1;
    step(4'b0000, 1'b1, 2'd0);
    step(4'b0000, 1'b0, 2'd0);
    step(4'b0000, 1'b0, 2'd0);
    pause = 1'b0;
    step(4'b0010, 1'b0, 2'd0);
    step(4'b0001, 1'b1, 2'd1);
    step(4'b0010, 1'b1, 2'd0);

    req   = 4'b1111;
    reset = 1'b1;
    #1;
    exp_words  = '0;
    prev_valid = 1'b0;
    check_all(4'b0000, 1'b0, 2'd0);
    #1 reset = 1'b0;

    step(4'b0001, 1'b0, 2'd0);
    for (int n = 34; n <= 50; n++) begin
      step(4'b0001 << ((n - 33) % 4), 1'b1, 2'((n - 34) % 4));
      if (n == 49) begin
        n_cmp++;
        assert (words_out === 4'd15) else begin
          n_err++;
          $error("FAIL words_before_wrap: got %0d want 15", words_out);
        end
      end
    end
    n_cmp++;
    assert (words_out === 4'd0) else begin
      n_err++;
      $error("FAIL words_wrap: got %0d want 0", words_out);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
